// File: rtl/rob_alloc_if.sv
// Decode-to-allocator request channel: one instruction per cycle under valid/ready.
interface rob_alloc_if #(
  parameter int ADDR_LEN = 32,
  parameter int REG_SEL  = 5
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [ADDR_LEN-1:0] req_pc_i;
  logic                req_dstvalid_i;
  logic [REG_SEL-1:0]  req_dst_i;

  modport master (output req_valid_i, req_pc_i, req_dstvalid_i, req_dst_i, input  req_ready_o);
  modport slave  (input  req_valid_i, req_pc_i, req_dstvalid_i, req_dst_i, output req_ready_o);
endinterface

// File: rtl/rob_alloc.sv
// ROB dispatch allocator: hands out ROB entries in order and tracks occupancy from commit counts.
// Optional ROB_ALLOC_FLUSH_EN adds flush_i/flush_ptr_i to reinitialise the pointers on a pipeline flush.
module rob_alloc #(
  parameter int ROB_NUM  = 64,
  parameter int ROB_SEL  = 6,
  parameter int ADDR_LEN = 32,
  parameter int REG_SEL  = 5
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  rob_alloc_if.slave          req,
  input  logic                comnum_i,
  output logic                dp1_o,
  output logic [ROB_SEL-1:0]  dp1_addr_o,
  output logic [ADDR_LEN-1:0] pc_dp1_o,
  output logic                dstvalid_dp1_o,
  output logic [REG_SEL-1:0]  dst_dp1_o,
  output logic [ROB_SEL-1:0]  alloc_ptr_o,
  output logic [ROB_SEL:0]    freenum_o,
  output logic                err_o
`ifdef ROB_ALLOC_FLUSH_EN
  ,
  input  logic                flush_i,
  input  logic [ROB_SEL-1:0]  flush_ptr_i
`endif
);
  localparam logic [ROB_SEL:0] FULL_CNT = (ROB_SEL+1)'(ROB_NUM);

  logic               flush;
  logic [ROB_SEL-1:0] flush_ptr;
  logic               accept;
  logic               misuse;

`ifdef ROB_ALLOC_FLUSH_EN
  assign flush     = flush_i;
  assign flush_ptr = flush_ptr_i;
`else
  assign flush     = 1'b0;
  assign flush_ptr = '0;
`endif

  // Ready depends only on registered occupancy, so a commit into a full ROB shows up a cycle later.
  assign req.req_ready_o = (freenum_o != '0) && !flush;
  assign accept          = req.req_valid_i && req.req_ready_o;
  assign misuse          = comnum_i && !accept && (freenum_o == FULL_CNT);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      dp1_o          <= 1'b0;
      dp1_addr_o     <= '0;
      pc_dp1_o       <= '0;
      dstvalid_dp1_o <= 1'b0;
      dst_dp1_o      <= '0;
      alloc_ptr_o    <= '0;
      freenum_o      <= FULL_CNT;
      err_o          <= 1'b0;
    end else if (flush) begin
      dp1_o       <= 1'b0;
      alloc_ptr_o <= flush_ptr;
      freenum_o   <= FULL_CNT;
    end else begin
      dp1_o <= accept;
      if (accept) begin
        dp1_addr_o     <= alloc_ptr_o;
        pc_dp1_o       <= req.req_pc_i;
        dstvalid_dp1_o <= req.req_dstvalid_i;
        dst_dp1_o      <= req.req_dst_i;
        alloc_ptr_o    <= alloc_ptr_o + 1'b1;
      end
      // A commit with nothing in flight is an ROB bug: keep the count pinned and latch the error.
      if (misuse) err_o <= 1'b1;
      else        freenum_o <= freenum_o - (ROB_SEL+1)'(accept) + (ROB_SEL+1)'(comnum_i);
    end
  end
endmodule

// File: tb/tb_rob_alloc.sv
// Randomised and directed bench for rob_alloc against a queue-based occupancy model.
module tb_rob_alloc;
  localparam int ROB_NUM = 64, ROB_SEL = 6, ADDR_LEN = 32, REG_SEL = 5;

  logic clk_i = 1'b0, reset_ni = 1'b0, comnum_i = 1'b0;
  logic                dp1_o, dstvalid_dp1_o, err_o;
  logic [ROB_SEL-1:0]  dp1_addr_o, alloc_ptr_o;
  logic [ADDR_LEN-1:0] pc_dp1_o;
  logic [REG_SEL-1:0]  dst_dp1_o;
  logic [ROB_SEL:0]    freenum_o;
`ifdef ROB_ALLOC_FLUSH_EN
  logic               flush_i = 1'b0;
  logic [ROB_SEL-1:0] flush_ptr_i = '0;
`endif

  always #5 clk_i = ~clk_i;

  rob_alloc_if #(.ADDR_LEN(ADDR_LEN), .REG_SEL(REG_SEL)) rif();

  rob_alloc #(.ROB_NUM(ROB_NUM), .ROB_SEL(ROB_SEL), .ADDR_LEN(ADDR_LEN), .REG_SEL(REG_SEL)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .req(rif.slave), .comnum_i(comnum_i),
    .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o), .pc_dp1_o(pc_dp1_o),
    .dstvalid_dp1_o(dstvalid_dp1_o), .dst_dp1_o(dst_dp1_o),
    .alloc_ptr_o(alloc_ptr_o), .freenum_o(freenum_o), .err_o(err_o)
`ifdef ROB_ALLOC_FLUSH_EN
    , .flush_i(flush_i), .flush_ptr_i(flush_ptr_i)
`endif
  );

  // Reference: a queue of in-flight entry numbers, oldest first.
  int          q[$];
  int          mptr;
  bit          merr, ex_dp1, ex_dv;
  int          ex_addr;
  logic [31:0] ex_pc;
  logic [4:0]  ex_dst;
  int          chk = 0, errs = 0;

  function automatic int mfree();
    return ROB_NUM - q.size();
  endfunction

  task automatic tick(input bit v, input logic [31:0] pc, input bit dv, input logic [4:0] d,
                      input bit c, input bit f, input int fp);
    bit rdy, acc;
    rif.req_valid_i = v; rif.req_pc_i = pc; rif.req_dstvalid_i = dv; rif.req_dst_i = d;
    comnum_i = c;
`ifdef ROB_ALLOC_FLUSH_EN
    flush_i = f; flush_ptr_i = fp[ROB_SEL-1:0];
`endif
    rdy = (mfree() != 0) && !f;
    acc = v && rdy;
    @(posedge clk_i); #1;
    if (f) begin
      q.delete(); mptr = fp % ROB_NUM; ex_dp1 = 1'b0;
    end else begin
      ex_dp1 = acc;
      if (acc) begin
        ex_addr = mptr; ex_pc = pc; ex_dv = dv; ex_dst = d;
        q.push_back(mptr); mptr = (mptr + 1) % ROB_NUM;
      end
      if (c) begin
        if (q.size() > 0) void'(q.pop_front());
        else merr = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input bit v, input bit c);
    reset_ni = 1'b0;
    tick(v, 32'hDEAD_BEEF, 1'b1, 5'd7, c, 1'b0, 0);
    reset_ni = 1'b1;
    q.delete(); mptr = 0; merr = 0; ex_dp1 = 0; ex_addr = 0; ex_pc = 0; ex_dv = 0; ex_dst = 0;
    tick(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset();
    reset_ni = 1'b0;
    tick(1'b1, 32'h55, 1'b1, 5'd9, 1'b1, 1'b0, 0);
    chk++; if (dp1_o !== 1'b0) begin errs++; $display("FAIL reset_dp1 got %0h exp 0", dp1_o); end
    chk++; if ({dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o} !== '0) begin errs++; $display("FAIL reset_data got %0h/%0h/%0h/%0h exp 0", dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o); end
    chk++; if (alloc_ptr_o !== 0) begin errs++; $display("FAIL reset_ptr got %0d exp 0", alloc_ptr_o); end
    chk++; if (freenum_o !== ROB_NUM) begin errs++; $display("FAIL reset_free got %0d exp %0d", freenum_o, ROB_NUM); end
    chk++; if (err_o !== 1'b0) begin errs++; $display("FAIL reset_err got %0h exp 0", err_o); end
    reset_ni = 1'b1;
    q.delete(); mptr = 0; merr = 0; ex_dp1 = 0;
    rif.req_valid_i = 1'b0; comnum_i = 1'b0; #1;
    chk++; if (rif.req_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready got %0h exp 1", rif.req_ready_o); end
  endtask

  task automatic test_single();
    tick(1'b1, 32'h100, 1'b1, 5'd3, 1'b0, 1'b0, 0);
    chk++; if ({dp1_o, dp1_addr_o} !== {1'b1, 6'd0}) begin errs++; $display("FAIL single_dp got %0h/%0d exp 1/0", dp1_o, dp1_addr_o); end
    chk++; if ({pc_dp1_o, dstvalid_dp1_o, dst_dp1_o} !== {32'h100, 1'b1, 5'd3}) begin errs++; $display("FAIL single_data got %0h/%0h/%0d exp 100/1/3", pc_dp1_o, dstvalid_dp1_o, dst_dp1_o); end
    chk++; if ({alloc_ptr_o, freenum_o} !== {6'd1, 7'd63}) begin errs++; $display("FAIL single_cnt got %0d/%0d exp 1/63", alloc_ptr_o, freenum_o); end
  endtask

  task automatic test_fill_and_wrap();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < ROB_NUM; i++) begin
      tick(1'b1, 32'h1000 + 32'(i*4), i[0], 5'(i), 1'b0, 1'b0, 0);
      chk++; if ({dp1_o, dp1_addr_o} !== {1'b1, 6'(i)}) begin errs++; $display("FAIL fill_addr got %0h/%0d exp 1/%0d", dp1_o, dp1_addr_o, i); end
    end
    chk++; if ({freenum_o, rif.req_ready_o} !== {7'd0, 1'b0}) begin errs++; $display("FAIL full_state got %0d/%0h exp 0/0", freenum_o, rif.req_ready_o); end
    tick(1'b1, 32'hABC0, 1'b1, 5'd17, 1'b0, 1'b0, 0);
    chk++; if ({dp1_o, freenum_o} !== {1'b0, 7'd0}) begin errs++; $display("FAIL full_hold got %0h/%0d exp 0/0", dp1_o, freenum_o); end
    tick(1'b1, 32'hABC0, 1'b1, 5'd17, 1'b1, 1'b0, 0);
    chk++; if ({dp1_o, freenum_o} !== {1'b0, 7'd1}) begin errs++; $display("FAIL full_commit got %0h/%0d exp 0/1", dp1_o, freenum_o); end
    chk++; if (rif.req_ready_o !== 1'b1) begin errs++; $display("FAIL full_ready_rise got %0h exp 1", rif.req_ready_o); end
    tick(1'b1, 32'hABC0, 1'b1, 5'd17, 1'b0, 1'b0, 0);
    chk++; if ({dp1_o, dp1_addr_o, pc_dp1_o, dst_dp1_o} !== {1'b1, 6'd0, 32'hABC0, 5'd17}) begin errs++; $display("FAIL wrap_dp got %0h/%0d/%0h/%0d exp 1/0/abc0/17", dp1_o, dp1_addr_o, pc_dp1_o, dst_dp1_o); end
  endtask

  task automatic test_accept_commit();
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < ROB_NUM - 10; i++) tick(1'b1, 32'(i), 1'b0, 5'd0, 1'b0, 1'b0, 0);
    chk++; if (freenum_o !== 7'd10) begin errs++; $display("FAIL ac_pre got %0d exp 10", freenum_o); end
    tick(1'b1, 32'h77, 1'b1, 5'd1, 1'b1, 1'b0, 0);
    chk++; if ({freenum_o, alloc_ptr_o} !== {7'd10, 6'd55}) begin errs++; $display("FAIL ac_same got %0d/%0d exp 10/55", freenum_o, alloc_ptr_o); end
  endtask

  task automatic test_empty_err();
    do_reset(1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0, 0);
    chk++; if ({freenum_o, err_o} !== {7'd64, 1'b1}) begin errs++; $display("FAIL empty_err got %0d/%0h exp 64/1", freenum_o, err_o); end
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h20, 1'b0, 5'd2, 1'b1, 1'b0, 0);
    chk++; if (err_o !== 1'b1) begin errs++; $display("FAIL err_sticky got %0h exp 1", err_o); end
    do_reset(1'b0, 1'b0);
    chk++; if (err_o !== 1'b0) begin errs++; $display("FAIL err_clear got %0h exp 0", err_o); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick(1'b1, 32'(i), 1'b1, 5'd4, 1'b0, 1'b0, 0);
    reset_ni = 1'b0;
    tick(1'b1, 32'h9, 1'b1, 5'd4, 1'b0, 1'b0, 0);
    chk++; if ({dp1_o, alloc_ptr_o, freenum_o} !== {1'b0, 6'd0, 7'd64}) begin errs++; $display("FAIL reset_mid got %0h/%0d/%0d exp 0/0/64", dp1_o, alloc_ptr_o, freenum_o); end
    do_reset(1'b0, 1'b0);
  endtask

  task automatic test_random();
    bit v, c, f;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      f = 1'b0;
`ifdef ROB_ALLOC_FLUSH_EN
      f = ($urandom_range(0, 40) == 0);
`endif
      tick(v, $urandom, 1'($urandom), 5'($urandom), c, f, int'($urandom_range(0, ROB_NUM-1)));
      chk++; if (dp1_o !== ex_dp1 || (ex_dp1 && {dp1_addr_o, pc_dp1_o, dstvalid_dp1_o, dst_dp1_o} !== {6'(ex_addr), ex_pc, ex_dv, ex_dst})) begin
        errs++; $display("FAIL rnd_dp cyc %0d got %0h/%0d/%0h exp %0h/%0d/%0h", i, dp1_o, dp1_addr_o, pc_dp1_o, ex_dp1, ex_addr, ex_pc); end
      chk++; if ({alloc_ptr_o, freenum_o, err_o} !== {6'(mptr), 7'(mfree()), merr}) begin
        errs++; $display("FAIL rnd_state cyc %0d got %0d/%0d/%0h exp %0d/%0d/%0h", i, alloc_ptr_o, freenum_o, err_o, mptr, mfree(), merr); end
    end
  endtask

`ifdef ROB_ALLOC_FLUSH_EN
  task automatic test_flush();
    do_reset(1'b0, 1'b0);
    tick(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 60);
    for (int i = 0; i < 24; i++) tick(1'b1, 32'(i), 1'b0, 5'd0, 1'b0, 1'b0, 0);
    chk++; if ({alloc_ptr_o, freenum_o} !== {6'd20, 7'd40}) begin errs++; $display("FAIL flush_pre got %0d/%0d exp 20/40", alloc_ptr_o, freenum_o); end
    tick(1'b1, 32'h44, 1'b1, 5'd5, 1'b1, 1'b1, 12);
    chk++; if ({dp1_o, alloc_ptr_o, freenum_o, err_o} !== {1'b0, 6'd12, 7'd64, 1'b0}) begin errs++; $display("FAIL flush got %0h/%0d/%0d/%0h exp 0/12/64/0", dp1_o, alloc_ptr_o, freenum_o, err_o); end
    chk++; if (rif.req_ready_o !== 1'b0) begin errs++; $display("FAIL flush_ready got %0h exp 0", rif.req_ready_o); end
    tick(1'b1, 32'h48, 1'b0, 5'd6, 1'b0, 1'b0, 0);
    chk++; if ({dp1_o, dp1_addr_o} !== {1'b1, 6'd12}) begin errs++; $display("FAIL flush_next got %0h/%0d exp 1/12", dp1_o, dp1_addr_o); end
  endtask
`endif

  initial begin
    rif.req_valid_i = 1'b0; rif.req_pc_i = '0; rif.req_dstvalid_i = 1'b0; rif.req_dst_i = '0;
    test_reset();
    test_single();
    test_fill_and_wrap();
    test_accept_commit();
    test_empty_err();
    test_reset_mid();
`ifdef ROB_ALLOC_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule

// File: doc/rob_alloc.md
# rob_alloc

- Dispatch-side allocator for the reorder buffer.
- Accepts one decoded instruction per cycle through a valid/ready handshake and assigns it the next free ROB entry in order.
- Drives the ROB dispatch port (dp1, entry address, PC, destination fields) from registered outputs one cycle later.
- Reclaims entries from the ROB's per-cycle commit count, so ROB occupancy is tracked without reading ROB state.

## Interface
Parameters:
- ROB_NUM, 64, number of ROB entries; power of two.
- ROB_SEL, 6, log2(ROB_NUM); entry address width.
- ADDR_LEN, 32, PC width.
- REG_SEL, 5, architectural register index width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_ni  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  decode presents an instruction.
- req_ready_o  out  1  allocator can accept this cycle.
- req_pc_i  in  ADDR_LEN  instruction PC.
- req_dstvalid_i  in  1  instruction writes a destination register.
- req_dst_i  in  REG_SEL  destination logical register.
- comnum_i  in  1  ROB retired one entry this cycle.
- dp1_o  out  1  dispatch strobe to the ROB; registered.
- dp1_addr_o  out  ROB_SEL  allocated entry; registered.
- pc_dp1_o  out  ADDR_LEN  registered copy of req_pc_i.
- dstvalid_dp1_o  out  1  registered copy of req_dstvalid_i.
- dst_dp1_o  out  REG_SEL  registered copy of req_dst_i.
- alloc_ptr_o  out  ROB_SEL  entry the next accepted instruction receives.
- freenum_o  out  ROB_SEL+1  free entries, 0..ROB_NUM.
- err_o  out  1  sticky; set on commit with no entry in use.
- flush_i  in  1  present only with ROB_ALLOC_FLUSH_EN; discards all in-flight entries.
- flush_ptr_i  in  ROB_SEL  present only with ROB_ALLOC_FLUSH_EN; ROB commit pointer at flush.

## Operation
- Handshake:
  - req_ready_o = (freenum_o != 0); purely from registered state, no dependence on req_valid_i or comnum_i.
  - accept = req_valid_i & req_ready_o.
- On accept:
  - dp1_o <= 1 and dp1_addr_o <= alloc_ptr_o.
  - pc/dstvalid/dst outputs <= request fields.
  - alloc_ptr_o <= (alloc_ptr_o + 1) mod ROB_NUM; the wrap from ROB_NUM-1 to 0 is natural truncation.
- No accept: dp1_o <= 0; data outputs hold their previous values, but are don't-care while dp1_o = 0.
- Free count: freenum_o <= freenum_o - accept + comnum_i.
  - Accept and commit in the same cycle: count unchanged.
  - Full (freenum_o = 0): ready low; a commit raises the count to 1 and ready rises the next cycle, never in the same cycle.
- Empty misuse (comnum_i = 1 while freenum_o = ROB_NUM and no accept):
  - freenum_o saturates at ROB_NUM.
  - err_o <= 1, held until reset.
- Allocation order: strictly sequential, so with the ROB commit pointer starting at 0 the in-use entries are always [commit_ptr, alloc_ptr) modulo ROB_NUM.

## Timing
- Reset (reset_ni = 0 at a clock edge), all state:
  - alloc_ptr_o = 0, freenum_o = ROB_NUM.
  - dp1_o = 0, dp1_addr_o = 0, pc_dp1_o = 0, dstvalid_dp1_o = 0, dst_dp1_o = 0.
  - err_o = 0.
  - Reset overrides accept, commit and flush.
  - req_ready_o reads 1 in the first cycle after reset is released.
- Latency:
  - Accepted in cycle N → dp1_o high in cycle N+1 with that entry's address.
  - alloc_ptr_o and freenum_o also update at the N→N+1 edge.
- Throughput: one instruction per cycle when not full; back-to-back accepts give consecutive addresses.
- Reset mid-stream: any pending dispatch is dropped and dp1_o is 0 in the cycle after reset.

## Configuration
- ROB_ALLOC_FLUSH_EN defined:
  - flush_i and flush_ptr_i exist.
  - A flush_i = 1 edge sets alloc_ptr_o <= flush_ptr_i, freenum_o <= ROB_NUM, dp1_o <= 0.
  - Flush takes priority over accept and comnum_i, and err_o is not updated in that cycle.
  - req_ready_o is forced 0 while flush_i = 1.
- ROB_ALLOC_FLUSH_EN undefined: both ports are absent and only reset reinitialises the pointers.

## Test plan
- Reset then one request (pc=0x100, dst=3, dstvalid=1) → next cycle: dp1_o=1, dp1_addr_o=0, pc_dp1_o=0x100, dst_dp1_o=3; alloc_ptr_o=1; freenum_o=63.
- 64 consecutive requests with no commits → addresses 0..63 in order; freenum_o=0; req_ready_o=0; a 65th valid request is held and no dp1_o pulse occurs.
- Full, then comnum_i=1 for one cycle → freenum_o=1; ready rises the following cycle; the held request receives address 0 (wrap).
- Request accepted and comnum_i=1 in the same cycle at freenum_o=10 → freenum_o stays 10; alloc_ptr_o advances by 1.
- comnum_i=1 straight after reset → freenum_o stays 64; err_o=1; err_o persists until reset_ni=0.
- With ROB_ALLOC_FLUSH_EN: alloc_ptr_o=20, freenum_o=40, then flush_i=1 with flush_ptr_i=12 and a simultaneous request → request not accepted; alloc_ptr_o=12; freenum_o=64; dp1_o=0.
